// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: sequential ROM fetch, DEPTH-entry {pc,inst} buffer.
// Define FETCHQ_DELAY_SLOT_EN to keep one delay-slot entry on a redirect.
module inst_fetch_queue #(
  parameter int                DEPTH    = 4,
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       rom_ce_o,
  output logic [ADDR_W-1:0]          rom_addr_o,
  input  logic [DATA_W-1:0]          rom_data_i,
  output logic                       id_valid_o,
  output logic [ADDR_W-1:0]          id_pc_o,
  output logic [DATA_W-1:0]          id_inst_o,
  input  logic                       stall_i,
  input  logic                       redirect_i,
  input  logic [ADDR_W-1:0]          redirect_pc_i,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [ADDR_W-1:0] pc_q   [DEPTH];
  logic [DATA_W-1:0] inst_q [DEPTH];

  logic [PW-1:0]     head_q, head_d;
  logic [PW-1:0]     tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] req_pc_q;
  logic              inflight_q;

  logic              id_valid;
  logic              pop;
  logic              redir;
  logic              push;
  logic              issue;
  logic [CW:0]       occ;

  assign id_valid = (count_q != '0);
  assign pop      = id_valid && !stall_i;
  assign redir    = redirect_i && pop;
  assign occ      = {1'b0, count_q} + (CW+1)'(inflight_q);
  assign issue    = !rst && (occ < (CW+1)'(DEPTH)) && !redir;

  assign rom_ce_o   = issue;
  assign rom_addr_o = fetch_pc_q;
  assign id_valid_o = id_valid;
  assign id_pc_o    = id_valid ? pc_q[head_q]   : '0;
  assign id_inst_o  = id_valid ? inst_q[head_q] : '0;
  assign count_o    = count_q;

`ifdef FETCHQ_DELAY_SLOT_EN
  logic              ds_pending_q;
  logic [ADDR_W-1:0] tgt_q;
  logic              ds_set;
`endif

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    fetch_pc_d = fetch_pc_q;
    push       = 1'b0;
`ifdef FETCHQ_DELAY_SLOT_EN
    ds_set     = 1'b0;
    if (issue)
      fetch_pc_d = ds_pending_q ? tgt_q : fetch_pc_q + ADDR_W'(4);
`else
    if (issue)
      fetch_pc_d = fetch_pc_q + ADDR_W'(4);
`endif
    if (redir) begin
`ifdef FETCHQ_DELAY_SLOT_EN
      // Head pops; the slot after it (queued, arriving, or yet to fetch) stays.
      fetch_pc_d = redirect_pc_i;
      head_d     = head_q + PW'(1);
      count_d    = CW'(1);
      if (count_q >= CW'(2)) begin
        tail_d = head_q + PW'(1) + PW'(1);
      end else if (inflight_q) begin
        push   = 1'b1;
        tail_d = tail_q + PW'(1);
      end else begin
        count_d    = '0;
        ds_set     = 1'b1;
        fetch_pc_d = pc_q[head_q] + ADDR_W'(4);
      end
`else
      fetch_pc_d = redirect_pc_i;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
`endif
    end else begin
      push = inflight_q;
      if (push) tail_d = tail_q + PW'(1);
      if (pop)  head_d = head_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
      inflight_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= issue;
      if (issue) req_pc_q <= fetch_pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_q[tail_q]   <= req_pc_q;
      inst_q[tail_q] <= rom_data_i;
    end
  end

`ifdef FETCHQ_DELAY_SLOT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ds_pending_q <= 1'b0;
      tgt_q        <= RESET_PC;
    end else if (ds_set) begin
      ds_pending_q <= 1'b1;
      tgt_q        <= redirect_pc_i;
    end else if (issue) begin
      ds_pending_q <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: directed scenarios plus random stall/redirect
// traffic against a queue-level reference model.
module tb_inst_fetch_queue;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rom_ce_o;
  logic [31:0]   rom_addr_o;
  logic [31:0]   rom_data_i;
  logic          id_valid_o;
  logic [31:0]   id_pc_o;
  logic [31:0]   id_inst_o;
  logic          stall_i = 1'b0;
  logic          redirect_i = 1'b0;
  logic [31:0]   redirect_pc_i = '0;
  logic [CW-1:0] count_o;

  int nvec = 0;
  int nerr = 0;

  logic [31:0] q[$];
  logic [31:0] mfetch = '0;
  logic        minfl = 1'b0;
  logic [31:0] minfl_pc = '0;
  logic        mds = 1'b0;
  logic [31:0] mtgt = '0;

  inst_fetch_queue #(
    .DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32), .RESET_PC(32'h0)
  ) dut (
    .clk(clk), .rst(rst),
    .rom_ce_o(rom_ce_o), .rom_addr_o(rom_addr_o), .rom_data_i(rom_data_i),
    .id_valid_o(id_valid_o), .id_pc_o(id_pc_o), .id_inst_o(id_inst_o),
    .stall_i(stall_i), .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i), .count_o(count_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_fn(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9bdf;
  endfunction

  always @(posedge clk)
    if (rom_ce_o) rom_data_i <= rom_fn(rom_addr_o);

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset();
    chk("rst_ce",    32'(rom_ce_o),   32'd0);
    chk("rst_addr",  rom_addr_o,      32'd0);
    chk("rst_valid", 32'(id_valid_o), 32'd0);
    chk("rst_pc",    id_pc_o,         32'd0);
    chk("rst_inst",  id_inst_o,       32'd0);
    chk("rst_count", 32'(count_o),    32'd0);
  endtask

  task automatic step(input logic st, input logic rd,
                      input logic [31:0] rpc, input bit rpulse);
    int          sz;
    logic        vld, acc, ece;
    logic [31:0] hpc, nf, keep;
    stall_i       = st;
    redirect_i    = rd;
    redirect_pc_i = rpc;
    if (rpulse) begin
      #1 rst = 1'b1;
      #1 chk_reset();
      q.delete();
      mfetch = '0;
      minfl  = 1'b0;
      mds    = 1'b0;
      #1 rst = 1'b0;
    end
    #1;
    sz  = q.size();
    vld = (sz > 0);
    hpc = vld ? q[0] : 32'h0;
    acc = rd && vld && !st;
    ece = ((sz + int'(minfl)) < DEPTH) && !acc;
    chk("rom_ce",   32'(rom_ce_o),   32'(ece));
    chk("rom_addr", rom_addr_o,      mfetch);
    chk("id_valid", 32'(id_valid_o), 32'(vld));
    chk("id_pc",    id_pc_o,         hpc);
    chk("id_inst",  id_inst_o,       vld ? rom_fn(hpc) : 32'h0);
    chk("count",    32'(count_o),    32'(sz));
    nf = mfetch;
    if (acc) begin
`ifdef FETCHQ_DELAY_SLOT_EN
      if (sz >= 2) begin
        keep = q[1];
        q.delete();
        q.push_back(keep);
        nf = rpc;
      end else if (minfl) begin
        q.delete();
        q.push_back(minfl_pc);
        nf = rpc;
      end else begin
        q.delete();
        mds  = 1'b1;
        mtgt = rpc;
        nf   = hpc + 32'd4;
      end
`else
      q.delete();
      nf = rpc;
`endif
    end else begin
      if (vld && !st) void'(q.pop_front());
      if (minfl) q.push_back(minfl_pc);
    end
    if (ece) begin
      nf  = mds ? mtgt : mfetch + 32'd4;
      mds = 1'b0;
    end
    minfl_pc = mfetch;
    minfl    = ece;
    mfetch   = nf;
    @(posedge clk);
    #1;
    stall_i    = 1'b0;
    redirect_i = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic        st, rd, pl;
    logic [31:0] rpc;
    repeat (2) @(negedge clk);
    chk_reset();
    rst = 1'b0;

    // stream, then fill under stall, then drain
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("first_valid", 32'(id_valid_o), 32'd1);
    chk("first_pc",    id_pc_o,         32'd0);
    chk("first_inst",  id_inst_o,       rom_fn(32'd0));
    repeat (6) step(1, 0, 0, 0);
    chk("full_count", 32'(count_o),  32'd4);
    chk("full_ce",    32'(rom_ce_o), 32'd0);
    repeat (8) step(0, 0, 0, 0);

    // redirect from head 0x10 to 0x100
    step(0, 0, 0, 1);
    repeat (5) step(0, 0, 0, 0);
    chk("redir_head", id_pc_o, 32'h10);
    step(0, 1, 32'h100, 0);
    chk("redir_t1_addr", rom_addr_o, 32'h100);
`ifdef FETCHQ_DELAY_SLOT_EN
    chk("redir_t1_count", 32'(count_o), 32'd1);
    chk("redir_t1_ds",    id_pc_o,      32'h14);
`else
    chk("redir_t1_count", 32'(count_o),    32'd0);
    chk("redir_t1_valid", 32'(id_valid_o), 32'd0);
`endif
    step(0, 0, 0, 0);
    chk("redir_t2_valid", 32'(id_valid_o), 32'd0);
    step(0, 0, 0, 0);
    chk("redir_t3_pc", id_pc_o, 32'h100);
    repeat (3) step(0, 0, 0, 0);

    // full queue, redirect to 0x1C, pop, redirect twice back to back
    step(1, 0, 0, 1);
    repeat (4) step(1, 0, 0, 0);
    chk("ds_full", 32'(count_o), 32'd4);
    step(0, 1, 32'h1C, 0);
    repeat (4) step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 1, 32'h300, 0);
`ifdef FETCHQ_DELAY_SLOT_EN
    chk("ds1_head",  id_pc_o,      32'h20);
    chk("ds1_count", 32'(count_o), 32'd1);
`endif
    step(0, 1, 32'h200, 0);
`ifdef FETCHQ_DELAY_SLOT_EN
    chk("ds1_issue_slot", rom_addr_o, 32'h24);
`endif
    step(0, 0, 0, 0);
`ifdef FETCHQ_DELAY_SLOT_EN
    chk("ds1_issue_tgt", rom_addr_o, 32'h200);
`endif
    step(0, 0, 0, 0);
`ifdef FETCHQ_DELAY_SLOT_EN
    chk("ds1_see_slot", id_pc_o, 32'h24);
`endif
    step(0, 0, 0, 0);
`ifdef FETCHQ_DELAY_SLOT_EN
    chk("ds1_see_tgt", id_pc_o, 32'h200);
`endif
    repeat (2) step(0, 0, 0, 0);

    // address wrap at the top of the space
    step(0, 0, 0, 0);
    while (!id_valid_o) step(0, 0, 0, 0);
    step(0, 1, 32'hFFFF_FFF8, 0);
    repeat (8) step(0, 0, 0, 0);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      st  = ($urandom_range(0, 9) < 3);
      rd  = ($urandom_range(0, 9) == 0);
      pl  = ($urandom_range(0, 99) == 0);
      rpc = ($urandom_range(0, 3) == 0)
            ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 3) * 4)
            : ($urandom & 32'hFFFF_FFFC);
      step(st, rd, rpc, pl);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
